fft_pass_sequencer: RTL and testbench

// - Sequences one 1-D FFT/iFFT pass over the PME grid bank. Streams FRAME_LEN-point frames from grid memory into the FFT

---
 rtl/fft_pass_sequencer_if.sv | 36 +++
 rtl/fft_pass_sequencer.sv | 103 ++++++++++
 tb/tb_fft_pass_sequencer.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fft_pass_sequencer_if.sv
// fft_pass_sequencer_if: controller, grid memory and FFT sink/source signals of one FFT pass
interface fft_pass_sequencer_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  start;
  logic [2:0]            dim_in;
  logic                  direction_in;
  logic                  busy;
  logic                  done;
  logic                  err_timeout;
  logic                  err_framing;
  logic [2:0]            dim;
  logic                  memRdEn;
  logic [ADDR_WIDTH-1:0] memRdAddr;
  logic                  memWen;
  logic [ADDR_WIDTH-1:0] memWrAddr;
  logic                  FFTsinkReady;
  logic                  FFTsinkValid;
  logic                  FFTsop;
  logic                  FFTeop;
  logic                  FFTdirection;
  logic                  FFTsourceValid;
  logic                  FFTsourceSop;
  logic                  FFTsourceEop;
  logic                  FFTsourceReady;
  modport master (
    output start, dim_in, direction_in, FFTsinkReady, FFTsourceValid, FFTsourceSop, FFTsourceEop,
    input  busy, done, err_timeout, err_framing, dim, memRdEn, memRdAddr, memWen, memWrAddr,
           FFTsinkValid, FFTsop, FFTeop, FFTdirection, FFTsourceReady
  );
  modport slave (
    input  start, dim_in, direction_in, FFTsinkReady, FFTsourceValid, FFTsourceSop, FFTsourceEop,
    output busy, done, err_timeout, err_framing, dim, memRdEn, memRdAddr, memWen, memWrAddr,
           FFTsinkValid, FFTsop, FFTeop, FFTdirection, FFTsourceReady
  );
endinterface

// File: rtl/fft_pass_sequencer.sv
// fft_pass_sequencer: streams one FFT pass from grid memory to the FFT core and writes results back in place
module fft_pass_sequencer #(
  parameter int FRAME_LEN     = 32,
  parameter int NUM_FRAMES    = 32,
  parameter int ADDR_WIDTH    = 11,
  parameter int DRAIN_TIMEOUT = 256
) (
  input logic                clk,
  input logic                rst,
  fft_pass_sequencer_if.slave io
);
  localparam int TOTAL = FRAME_LEN * NUM_FRAMES;
  localparam int CW    = ADDR_WIDTH + 1;
  localparam int LW    = $clog2(FRAME_LEN);
  localparam int IW    = $clog2(DRAIN_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, FEED, DRAIN, DONE} state_t;
  state_t          state_q, state_d;
  logic [CW-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
  logic [IW-1:0]   idle_cnt_q, idle_cnt_d;
  logic [2:0]      dim_q, dim_d;
  logic            dir_q, dir_d;
  logic            err_to_q, err_to_d, err_fr_q, err_fr_d;
  logic            sink_vld_q, sop_q, eop_q;
  logic            busy, active, rd, acc, wen, fr_bad;
  always_comb begin
    busy       = state_q != IDLE;
    active     = state_q == FEED || state_q == DRAIN;
    rd         = state_q == FEED && io.FFTsinkReady && rd_cnt_q < CW'(TOTAL);
    acc        = active && io.FFTsourceValid;
    wen        = acc && wr_cnt_q < CW'(TOTAL);
    // beats past the end of the pass count as framing faults too
    fr_bad     = !wen || io.FFTsourceSop != (wr_cnt_q[LW-1:0] == '0) ||
                 io.FFTsourceEop != (&wr_cnt_q[LW-1:0]);
    rd_cnt_d   = rd_cnt_q + CW'(rd);
    wr_cnt_d   = wr_cnt_q + CW'(wen);
    idle_cnt_d = (state_q == DRAIN && !acc) ? idle_cnt_q + 1'b1 : '0;
    dim_d      = dim_q;
    dir_d      = dir_q;
    err_to_d   = err_to_q;
    err_fr_d   = err_fr_q || (acc && fr_bad);
    state_d    = state_q;
    case (state_q)
      IDLE: if (io.start) begin
        state_d  = FEED;
        rd_cnt_d = '0;
        wr_cnt_d = '0;
        dim_d    = io.dim_in;
        dir_d    = io.direction_in;
        err_to_d = 1'b0;
        err_fr_d = 1'b0;
      end
      FEED: state_d = (rd && rd_cnt_q == CW'(TOTAL - 1)) ? DRAIN : FEED;
      // the final beat has priority over a coincident timeout
      DRAIN: if (wr_cnt_d == CW'(TOTAL)) state_d = DONE;
        else if (idle_cnt_q == IW'(DRAIN_TIMEOUT)) begin
          state_d  = IDLE;
          err_to_d = 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      idle_cnt_q <= '0;
      dim_q      <= '0;
      dir_q      <= 1'b0;
      err_to_q   <= 1'b0;
      err_fr_q   <= 1'b0;
      sink_vld_q <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      dim_q      <= dim_d;
      dir_q      <= dir_d;
      err_to_q   <= err_to_d;
      err_fr_q   <= err_fr_d;
      sink_vld_q <= rd;
      sop_q      <= rd && rd_cnt_q[LW-1:0] == '0;
      eop_q      <= rd && (&rd_cnt_q[LW-1:0]);
    end
  end
  assign io.busy           = busy;
  assign io.done           = state_q == DONE;
  assign io.err_timeout    = err_to_q;
  assign io.err_framing    = err_fr_q;
  assign io.dim            = busy ? dim_q : 3'b000;
  assign io.memRdEn        = rd;
  assign io.memRdAddr      = rd ? rd_cnt_q[ADDR_WIDTH-1:0] : '0;
  assign io.memWen         = wen;
  assign io.memWrAddr      = wen ? wr_cnt_q[ADDR_WIDTH-1:0] : '0;
  assign io.FFTsinkValid   = sink_vld_q;
  assign io.FFTsop         = sop_q;
  assign io.FFTeop         = eop_q;
  assign io.FFTdirection   = busy && dir_q;
  assign io.FFTsourceReady = active;
endmodule

// File: tb/tb_fft_pass_sequencer.sv
// tb_fft_pass_sequencer: randomized pass scenarios scored against a transaction-level model of one FFT pass
module tb_fft_pass_sequencer;
  localparam int FL = 32, NF = 32, AW = 11, TO = 256, TOTAL = FL * NF, LAT = 40;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fft_pass_sequencer_if #(.ADDR_WIDTH(AW)) io ();
  fft_pass_sequencer #(.FRAME_LEN(FL), .NUM_FRAMES(NF), .ADDR_WIDTH(AW), .DRAIN_TIMEOUT(TO))
    dut (.clk(clk), .rst(rst), .io(io));
  int checks = 0, errors = 0;
  int cyc = 0, ready_mode = 0, src_limit = TOTAL, bad_beat = -1, src_sent = 0;
  int due_q[$], rd_log[$], wr_log[$];
  int n_sink, sink_bad, rd_nready, n_done, prev_rd, first_rd_cyc, last_rd_cyc, last_wr_cyc;
  bit start_v = 1'b0, rst_v = 1'b1, dir_v = 1'b0;
  logic [2:0] dim_v = 3'b000;
  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] outs();
    return 64'({io.busy, io.done, io.err_timeout, io.err_framing, io.dim, io.memRdEn, io.memRdAddr,
                io.memWen, io.memWrAddr, io.FFTsinkValid, io.FFTsop, io.FFTeop, io.FFTdirection,
                io.FFTsourceReady});
  endfunction
  task automatic clear_env();
    due_q.delete(); rd_log.delete(); wr_log.delete();
    src_sent = 0; n_sink = 0; sink_bad = 0; rd_nready = 0; n_done = 0; prev_rd = -1;
    first_rd_cyc = 0; last_rd_cyc = 0; last_wr_cyc = 0;
  endtask
  // one clock: drive just after the edge, observe mid-cycle
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    rst = rst_v;
    io.start = start_v;
    io.dim_in = dim_v;
    io.direction_in = dir_v;
    io.FFTsinkReady = ready_mode == 0 ? 1'b1 : ready_mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
    io.FFTsourceValid = 1'b0;
    io.FFTsourceSop = 1'b0;
    io.FFTsourceEop = 1'b0;
    if (due_q.size() > 0 && due_q[0] <= cyc && src_sent < src_limit) begin
      void'(due_q.pop_front());
      io.FFTsourceValid = 1'b1;
      io.FFTsourceSop = (src_sent % FL == 0) ^ (src_sent == bad_beat);
      io.FFTsourceEop = src_sent % FL == FL - 1;
      src_sent++;
    end
    @(negedge clk);
    if (io.memRdEn) begin
      rd_log.push_back(int'(io.memRdAddr));
      if (!io.FFTsinkReady) rd_nready++;
      if (rd_log.size() == 1) first_rd_cyc = cyc;
      last_rd_cyc = cyc;
    end
    if (io.FFTsinkValid) begin
      n_sink++;
      due_q.push_back(cyc + LAT);
      if (prev_rd < 0 || io.FFTsop != (prev_rd % FL == 0) || io.FFTeop != (prev_rd % FL == FL - 1))
        sink_bad++;
    end else if (prev_rd >= 0) sink_bad++;
    prev_rd = io.memRdEn ? int'(io.memRdAddr) : -1;
    if (io.memWen) begin
      wr_log.push_back(int'(io.memWrAddr));
      last_wr_cyc = cyc;
    end
    if (io.done) n_done++;
  endtask
  task automatic start_pass(logic [2:0] d, bit dr, int mode, int limit, int bad);
    clear_env();
    ready_mode = mode; src_limit = limit; bad_beat = bad; dim_v = d; dir_v = dr;
    start_v = 1'b1;
    tick();
    start_v = 1'b0;
    tick();
    check_eq("start_busy", io.busy, 1);
    check_eq("start_dim", io.dim, d);
    check_eq("start_dir", io.FFTdirection, dr);
    check_eq("start_err_clr", {io.err_timeout, io.err_framing}, 0);
  endtask
  task automatic wait_idle(int max_cyc);
    for (int i = 0; i < max_cyc && io.busy; i++) tick();
    check_eq("pass_end", io.busy, 0);
  endtask
  task automatic verify_full(bit exp_fr, int mode);
    int bad_rd = 0, bad_wr = 0;
    foreach (rd_log[i]) if (rd_log[i] != i) bad_rd++;
    foreach (wr_log[i]) if (wr_log[i] != i) bad_wr++;
    check_eq("rd_count", rd_log.size(), TOTAL);
    check_eq("rd_order", bad_rd, 0);
    check_eq("rd_when_ready", rd_nready, 0);
    check_eq("sink_count", n_sink, TOTAL);
    check_eq("sink_beats", sink_bad, 0);
    check_eq("wr_count", wr_log.size(), TOTAL);
    check_eq("wr_order", bad_wr, 0);
    check_eq("done_once", n_done, 1);
    check_eq("err_framing", io.err_framing, exp_fr);
    check_eq("err_timeout", io.err_timeout, 0);
    if (mode == 0) check_eq("rd_back_to_back", last_rd_cyc - first_rd_cyc, TOTAL - 1);
  endtask
  initial begin
    io.start = 1'b0; io.dim_in = '0; io.direction_in = 1'b0; io.FFTsinkReady = 1'b0;
    io.FFTsourceValid = 1'b0; io.FFTsourceSop = 1'b0; io.FFTsourceEop = 1'b0;
    clear_env();
    repeat (3) tick();
    rst_v = 1'b0;
    tick();
    check_eq("reset_outs", outs(), 0);
    // clean pass, full-rate sink
    start_pass(3'b001, 1'b1, 0, TOTAL, -1);
    wait_idle(4000);
    verify_full(1'b0, 0);
    // sink ready every other cycle
    start_pass(3'b010, 1'b0, 1, TOTAL, -1);
    wait_idle(5000);
    verify_full(1'b0, 1);
    // source stalls after 1000 beats
    start_pass(3'b100, 1'b0, 0, 1000, -1);
    wait_idle(4000);
    check_eq("to_err_timeout", io.err_timeout, 1);
    check_eq("to_no_done", n_done, 0);
    check_eq("to_wr_count", wr_log.size(), 1000);
    check_eq("to_gap_ok", (cyc - last_wr_cyc) inside {[TO + 1 : TO + 2]}, 1);
    // misplaced sop on beat 32, random sink ready
    start_pass(3'b001, 1'b0, 2, TOTAL, 32);
    wait_idle(6000);
    verify_full(1'b1, 2);
    // reset mid-feed after 500 reads
    start_pass(3'b010, 1'b1, 0, TOTAL, -1);
    for (int i = 0; i < 3000 && rd_log.size() < 500; i++) tick();
    check_eq("rst_at_500", rd_log.size(), 500);
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    clear_env();
    tick();
    check_eq("rst_mid_outs", outs(), 0);
    // start together with reset is dropped
    rst_v = 1'b1; start_v = 1'b1;
    tick();
    rst_v = 1'b0; start_v = 1'b0;
    tick();
    check_eq("start_rst_busy", io.busy, 0);
    // clean pass with a stray start during feed
    start_pass(3'b010, 1'b0, 0, TOTAL, -1);
    repeat (100) tick();
    dim_v = 3'b100; dir_v = 1'b1; start_v = 1'b1;
    tick();
    start_v = 1'b0;
    tick();
    check_eq("busy_start_dim", io.dim, 3'b010);
    check_eq("busy_start_dir", io.FFTdirection, 0);
    wait_idle(4000);
    verify_full(1'b0, 0);
    check_eq("idle_outs", outs() & ~64'h3, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
